// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory boot loader: data width,
// length-field width and the loader FSM state encoding.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CKSUM  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/imem_loader_packer.sv
// word_packer: assembles little-endian bytes into a 32-bit word; byte 0 of a
// word lands in bits 7:0. word_next shows the word with the current byte inserted.
module word_packer
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            push,
  input  logic [7:0]      data,
  output logic [XLEN-1:0] word_next,
  output logic            word_full
);

  logic [1:0]      byte_idx;
  logic [XLEN-1:0] word;

  always_comb begin
    word_next = word;
    word_next[{byte_idx, 3'b000} +: 8] = data;
  end

  // Lane 3 being filled means this push completes the word.
  assign word_full = (byte_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_idx <= 2'd0;
    end else if (push) begin
      byte_idx <= byte_idx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      word <= word_next;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream writer for the instruction RAM.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CKSUM_EN.
module imem_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_wa,
  output logic [XLEN-1:0]   mem_wd,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int               DEPTH     = 2 ** ADDR_W;
  localparam logic [LEN_W:0]   DEPTH_EXT = (LEN_W + 1)'(DEPTH);

  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W:0]   widx;
  logic              accept;
  logic              push;
  logic              clear;
  logic              word_full;
  logic [XLEN-1:0]   word_next;
  logic [LEN_W:0]    len_ext;
  logic [LEN_W:0]    len_hi_ext;
  logic [LEN_W:0]    written;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]        csum;
`endif

  assign accept     = byte_valid && byte_ready;
  assign push       = accept && (state == S_DATA);
  assign clear      = (state == S_IDLE) && start;
  assign len_ext    = {1'b0, len};
  assign len_hi_ext = {1'b0, byte_data, len[7:0]};
  // Counts compared at 17 bits so a 16-bit length of 0xFFFF cannot wrap.
  assign written    = (LEN_W + 1)'(widx) + (LEN_W + 1)'(1);

  // Outputs decoded straight from the state register.
  assign byte_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                      (state == S_DATA)   || (state == S_CKSUM);
  assign mem_we     = (state == S_WRITE);
  assign cpu_hold   = (state != S_IDLE);
  assign done       = (state == S_DONE);

  word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (push),
    .data      (byte_data),
    .word_next (word_next),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      len    <= '0;
      widx   <= '0;
      mem_wa <= '0;
      mem_wd <= '0;
      err    <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
      csum   <= 8'h00;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_LEN_LO;
            err   <= 1'b0;
            widx  <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
            csum  <= 8'h00;
`endif
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len[7:0] <= byte_data;
            state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len[LEN_W-1:8] <= byte_data;
            if (len_hi_ext == '0) begin
`ifdef IMEM_LOADER_CKSUM_EN
              state <= S_CKSUM;
`else
              state <= S_DONE;
`endif
            end else if (len_hi_ext > DEPTH_EXT) begin
              err   <= 1'b1;
              state <= S_IDLE;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
`ifdef IMEM_LOADER_CKSUM_EN
            csum <= csum ^ byte_data;
`endif
            if (word_full) begin
              mem_wa <= widx[ADDR_W-1:0];
              mem_wd <= word_next;
              state  <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          widx <= widx + (ADDR_W + 1)'(1);
          if (written == len_ext) begin
`ifdef IMEM_LOADER_CKSUM_EN
            state <= S_CKSUM;
`else
            state <= S_DONE;
`endif
          end else begin
            state <= S_DATA;
          end
        end
`ifdef IMEM_LOADER_CKSUM_EN
        S_CKSUM: begin
          if (accept) begin
            if (byte_data == csum) begin
              state <= S_DONE;
            end else begin
              err   <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
`endif
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random words and handshake gaps checked
// against a word-array model of the expected instruction memory image.
module tb_imem_loader;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [31:0]       mem_wd;
  logic              cpu_hold;
  logic              done;
  logic              err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int we_cnt = 0;
  int done_cnt = 0;
  int we_cyc = 0;
  int done_cyc = 0;
  int fall_cyc = 0;
  int last_wa = 0;
  logic hold_q = 1'b0;

  logic [31:0] tbmem [DEPTH];
  logic [31:0] exp_w [DEPTH];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_wa     (mem_wa),
    .mem_wd     (mem_wd),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Memory-side observer: captures every write and event time.
  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt++;
      tbmem[mem_wa] = mem_wd;
      last_wa = int'(mem_wa);
      we_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (hold_q && !cpu_hold) fall_cyc = cyc;
    hold_q = cpu_hold;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int n;
    byte_valid = 1'b0;
    repeat ($urandom_range(0, gapmax)) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      chk("rdy_timeout", 32'(byte_ready), 32'd1);
      byte_valid = 1'b0;
    end else begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
  endtask

  task automatic run_load(input int n, input int gapmax);
    int we0, d0, w;
    logic [7:0] cs;
    logic [15:0] len16;
    for (int k = 0; k < DEPTH; k++) tbmem[k] = 32'hBAD0_0000 | k;
    we0 = we_cnt;
    d0  = done_cnt;
    cs  = 8'h00;
    len16 = 16'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hold_after_start", 32'(cpu_hold), 32'd1);
    chk("rdy_after_start", 32'(byte_ready), 32'd1);
    send_byte(len16[7:0], gapmax);
    send_byte(len16[15:8], gapmax);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 4; j++) begin
        cs = cs ^ exp_w[k][8*j +: 8];
        send_byte(exp_w[k][8*j +: 8], gapmax);
      end
    end
`ifdef IMEM_LOADER_CKSUM_EN
    send_byte(cs, gapmax);
`endif
    w = 0;
    while (done_cnt == d0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("done_count", 32'(done_cnt - d0), 32'd1);
    repeat (3) @(negedge clk);
    chk("we_count", 32'(we_cnt - we0), 32'(n));
    chk("err_low", 32'(err), 32'd0);
    chk("hold_low", 32'(cpu_hold), 32'd0);
    chk("hold_fall", 32'(fall_cyc), 32'(done_cyc + 1));
    if (n > 0) begin
      chk("last_wa", 32'(last_wa), 32'(n - 1));
`ifndef IMEM_LOADER_CKSUM_EN
      chk("done_after_we", 32'(done_cyc), 32'(we_cyc + 1));
`endif
    end
    for (int k = 0; k < n; k++) chk($sformatf("word%0d", k), tbmem[k], exp_w[k]);
  endtask

  initial begin
    int we0, d0, n;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_wa", 32'(mem_wa), 32'd0);
    chk("rst_wd", mem_wd, 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed two-word image, back-to-back then with random gaps.
    exp_w[0] = 32'h0050_0013;
    exp_w[1] = 32'h00A0_0093;
    run_load(2, 0);
    run_load(2, 4);

    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) exp_w[k] = $urandom;
      run_load(n, 3);
    end

    run_load(0, 1);

    for (int k = 0; k < DEPTH; k++) exp_w[k] = $urandom;
    run_load(DEPTH, 0);
    chk("full_wa0_kept", tbmem[0], exp_w[0]);

    // Oversized length: error, no writes, next start clears err.
    we0 = we_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h41, 0);
    send_byte(8'h00, 0);
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_hold", 32'(cpu_hold), 32'd0);
    chk("ovf_ready", 32'(byte_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("ovf_no_we", 32'(we_cnt - we0), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ovf_err_cleared", 32'(err), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Reset after six data bytes of a three-word load.
    for (int k = 0; k < DEPTH; k++) tbmem[k] = 32'hBAD0_0000 | k;
    for (int k = 0; k < 3; k++) exp_w[k] = $urandom;
    we0 = we_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    for (int b = 0; b < 6; b++) send_byte(exp_w[b / 4][8*(b % 4) +: 8], 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_ready", 32'(byte_ready), 32'd0);
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_wa", 32'(mem_wa), 32'd0);
    chk("mid_rst_wd", mem_wd, 32'd0);
    chk("mid_rst_hold", 32'(cpu_hold), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    repeat (5) @(negedge clk);
    chk("mid_rst_we_count", 32'(we_cnt - we0), 32'd1);
    chk("mid_rst_word0", tbmem[0], exp_w[0]);
    chk("mid_rst_word1", tbmem[1], 32'hBAD0_0001);

`ifdef IMEM_LOADER_CKSUM_EN
    // Bad checksum: word still written, err set, no done pulse.
    we0 = we_cnt;
    d0  = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    send_byte(8'h50, 0);
    send_byte(8'h00, 0);
    send_byte(8'h44, 0);
    repeat (4) @(negedge clk);
    chk("ck_bad_err", 32'(err), 32'd1);
    chk("ck_bad_no_done", 32'(done_cnt - d0), 32'd0);
    chk("ck_bad_we", 32'(we_cnt - we0), 32'd1);
    chk("ck_bad_word", tbmem[0], 32'h0050_0013);
    chk("ck_bad_hold", 32'(cpu_hold), 32'd0);
    exp_w[0] = 32'h0050_0013;
    run_load(1, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
